// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap/mret sequencer.
// Serves one CSR read-modify-write at a time and redirects fetch on trap/mret.
module csr_trap_unit #(
    parameter int          MXLEN       = 32,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             csr_req_valid,
    output logic             csr_req_ready,
    input  logic [1:0]       csr_op,
    input  logic [11:0]      csr_addr,
    input  logic [MXLEN-1:0] csr_wdata,
    output logic             csr_rsp_valid,
    output logic [MXLEN-1:0] csr_rdata,
    output logic             csr_rsp_illegal,
    input  logic             trap_valid,
    input  logic             trap_is_irq,
    input  logic [4:0]       trap_cause,
    input  logic [MXLEN-1:0] trap_pc,
    input  logic [MXLEN-1:0] trap_tval,
    input  logic             mret_valid,
    input  logic             irq_sw,
    input  logic             irq_tim,
    input  logic             irq_ext,
    output logic             irq_pending,
    output logic             redirect_valid,
    output logic [MXLEN-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CSR_EXEC = 2'd1,
        TRAP     = 2'd2,
        MRET     = 2'd3
    } state_t;

    localparam logic [31:0] MISA_VAL  = 32'h4000_1100;
    localparam logic [31:0] MIE_MASK  = 32'h0000_0888;
    localparam logic [31:0] MCAU_MASK = 32'h8000_001F;
    localparam logic [31:0] MTVEC_RST =
        {MTVEC_RESET[31:2], MTVEC_RESET[1] ? 2'b00 : MTVEC_RESET[1:0]};

    state_t state_q, state_d;

    logic        st_mie, st_mpie;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        tr_irq;
    logic [4:0]  tr_cause;
    logic [31:0] tr_pc, tr_tval;

    logic [31:0] mip_val, mstatus_val, rd_val, wr_val;
    logic        impl, ro, illegal, wen;

    assign mip_val     = {20'b0, irq_ext, 3'b0, irq_tim, 3'b0, irq_sw, 3'b0};
    assign mstatus_val = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign irq_pending = st_mie & (|(mip_val & mie_q));

    assign csr_req_ready = (state_q == IDLE) && !trap_valid && !mret_valid;

    // Next-state selection; trap beats mret beats CSR request in IDLE.
    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE: begin
                if (trap_valid)         state_d = TRAP;
                else if (mret_valid)    state_d = MRET;
                else if (csr_req_valid) state_d = CSR_EXEC;
                else                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Capture the accepted request so the execute cycle is self-contained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_op    <= 2'b00;
            req_addr  <= 12'h000;
            req_wdata <= 32'h0;
            tr_irq    <= 1'b0;
            tr_cause  <= 5'h0;
            tr_pc     <= 32'h0;
            tr_tval   <= 32'h0;
        end else if (state_q == IDLE) begin
            if (trap_valid) begin
                tr_irq   <= trap_is_irq;
                tr_cause <= trap_cause;
                tr_pc    <= trap_pc;
                tr_tval  <= trap_tval;
            end else if (csr_req_valid && !mret_valid) begin
                req_op    <= csr_op;
                req_addr  <= csr_addr;
                req_wdata <= csr_wdata;
            end
        end
    end

    // Address decode: read value, existence and read-only attribute.
    always_comb begin
        rd_val = 32'h0;
        impl   = 1'b1;
        ro     = (req_addr[11:10] == 2'b11);
        unique case (req_addr)
            12'h300: rd_val = mstatus_val;
            12'h301: begin rd_val = MISA_VAL; ro = 1'b1; end
            12'h304: rd_val = mie_q;
            12'h305: rd_val = mtvec_q;
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = mepc_q;
            12'h342: rd_val = mcause_q;
            12'h343: rd_val = mtval_q;
            12'h344: begin rd_val = mip_val; ro = 1'b1; end
            12'hF11: rd_val = 32'h0;
            12'hF12: rd_val = 32'h0;
            12'hF13: rd_val = 32'h0;
            12'hF14: rd_val = HART_ID;
            default: impl = 1'b0;
        endcase
    end

    assign illegal = !impl || ((req_op != 2'b00) && ro);

    // Read-modify-write operand for RW/RS/RC.
    always_comb begin
        wr_val = rd_val;
        unique case (req_op)
            2'b01:   wr_val = req_wdata;
            2'b10:   wr_val = rd_val | req_wdata;
            2'b11:   wr_val = rd_val & ~req_wdata;
            default: wr_val = rd_val;
        endcase
    end

    assign wen = (state_q == CSR_EXEC) && (req_op != 2'b00) && !illegal;

    assign csr_rsp_valid   = (state_q == CSR_EXEC);
    assign csr_rsp_illegal = csr_rsp_valid && illegal;
    assign csr_rdata       = (csr_rsp_valid && !illegal) ? rd_val : 32'h0;

    // Redirect target: trap vector or saved mepc.
    always_comb begin
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        unique case (state_q)
            TRAP: begin
                redirect_valid = 1'b1;
                redirect_pc    = {mtvec_q[31:2], 2'b00};
                if (mtvec_q[1:0] == 2'b01 && tr_irq)
                    redirect_pc = {mtvec_q[31:2], 2'b00} +
                                  {25'b0, tr_cause, 2'b00};
            end
            MRET: begin
                redirect_valid = 1'b1;
                redirect_pc    = mepc_q;
            end
            default: ;
        endcase
    end

    // CSR state: WARL writes, trap entry and mret updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= 32'h0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
        end else if (wen) begin
            unique case (req_addr)
                12'h300: begin
                    st_mie  <= wr_val[3];
                    st_mpie <= wr_val[7];
                end
                12'h304: mie_q <= wr_val & MIE_MASK;
                12'h305: mtvec_q <= {wr_val[31:2],
                                     wr_val[1] ? mtvec_q[1:0] : wr_val[1:0]};
                12'h340: mscratch_q <= wr_val;
                12'h341: mepc_q     <= wr_val & ~32'h3;
                12'h342: mcause_q   <= wr_val & MCAU_MASK;
                12'h343: mtval_q    <= wr_val;
                default: ;
            endcase
        end else if (state_q == TRAP) begin
            mepc_q   <= tr_pc & ~32'h3;
            mcause_q <= {tr_irq, 26'b0, tr_cause};
            mtval_q  <= tr_irq ? 32'h0 : tr_tval;
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
        end else if (state_q == MRET) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed stimulus with a transaction-level CSR model
// checked against the DUT on every falling edge.
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_req_valid = 1'b0;
    logic        csr_req_ready;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] csr_wdata = 32'h0;
    logic        csr_rsp_valid;
    logic [31:0] csr_rdata;
    logic        csr_rsp_illegal;
    logic        trap_valid = 1'b0;
    logic        trap_is_irq = 1'b0;
    logic [4:0]  trap_cause = 5'h0;
    logic [31:0] trap_pc = 32'h0;
    logic [31:0] trap_tval = 32'h0;
    logic        mret_valid = 1'b0;
    logic        irq_sw = 1'b0;
    logic        irq_tim = 1'b0;
    logic        irq_ext = 1'b0;
    logic        irq_pending;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int tests = 0;
    int fails = 0;

    csr_trap_unit #(
        .MXLEN(32),
        .HART_ID(32'd3),
        .MTVEC_RESET(32'h0000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rsp_valid(csr_rsp_valid), .csr_rdata(csr_rdata),
        .csr_rsp_illegal(csr_rsp_illegal),
        .trap_valid(trap_valid), .trap_is_irq(trap_is_irq),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_valid(mret_valid),
        .irq_sw(irq_sw), .irq_tim(irq_tim), .irq_ext(irq_ext),
        .irq_pending(irq_pending),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_ie, m_pie;
    logic [31:0] m_mie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
    logic        exp_rsp_v, exp_ill, exp_redir_v;
    logic [31:0] exp_rdata, exp_redir_pc;
    logic [1:0]  p_op;
    logic [11:0] p_addr;
    logic [31:0] p_wdata, p_pc, p_tval;
    logic        p_trap, p_irq;
    logic [4:0]  p_cause;

    function automatic logic [31:0] live_mip();
        live_mip = 32'h0;
        live_mip[3]  = irq_sw;
        live_mip[7]  = irq_tim;
        live_mip[11] = irq_ext;
    endfunction

    function automatic logic m_exists(input logic [11:0] a);
        m_exists = (a == 12'h300) || (a == 12'h301) || (a == 12'h304) ||
                   (a == 12'h305) || (a >= 12'h340 && a <= 12'h344) ||
                   (a >= 12'hF11 && a <= 12'hF14);
    endfunction

    function automatic logic m_legal(input logic [11:0] a, input logic [1:0] op);
        logic readonly;
        readonly = (a >= 12'hC00) || (a == 12'h301) || (a == 12'h344);
        m_legal = m_exists(a) && !(op != 2'b00 && readonly);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: m_read = 32'h1800 | ({31'b0, m_ie} << 3) | ({31'b0, m_pie} << 7);
            12'h301: m_read = 32'h4000_1100;
            12'h304: m_read = m_mie;
            12'h305: m_read = m_tvec;
            12'h340: m_read = m_scratch;
            12'h341: m_read = m_epc;
            12'h342: m_read = m_cause;
            12'h343: m_read = m_tval;
            12'h344: m_read = live_mip();
            12'hF14: m_read = 32'd3;
            default: m_read = 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_vector(input logic irq, input logic [4:0] c);
        logic [31:0] base;
        base = m_tvec & ~32'h3;
        if (irq && m_tvec[1:0] == 2'b01) m_vector = base + 32'd4 * c;
        else                             m_vector = base;
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: begin m_ie <= v[3]; m_pie <= v[7]; end
            12'h304: m_mie <= v & 32'h888;
            12'h305: m_tvec <= (v[1:0] >= 2'd2) ? ((v & ~32'h3) | (m_tvec & 32'h3)) : v;
            12'h340: m_scratch <= v;
            12'h341: m_epc <= v & ~32'h3;
            12'h342: m_cause <= v & 32'h8000_001F;
            12'h343: m_tval <= v;
            default: ;
        endcase
    endtask

    // Model: commit effects of the ending cycle, then predict the next one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ie <= 1'b0; m_pie <= 1'b0;
            m_mie <= 32'h0; m_tvec <= 32'h0; m_scratch <= 32'h0;
            m_epc <= 32'h0; m_cause <= 32'h0; m_tval <= 32'h0;
            exp_rsp_v <= 1'b0; exp_ill <= 1'b0; exp_rdata <= 32'h0;
            exp_redir_v <= 1'b0; exp_redir_pc <= 32'h0;
            p_op <= 2'b00; p_addr <= 12'h0; p_wdata <= 32'h0;
            p_trap <= 1'b0; p_irq <= 1'b0; p_cause <= 5'h0;
            p_pc <= 32'h0; p_tval <= 32'h0;
        end else begin
            if (exp_rsp_v && !exp_ill) begin
                case (p_op)
                    2'd1: m_write(p_addr, p_wdata);
                    2'd2: m_write(p_addr, exp_rdata | p_wdata);
                    2'd3: m_write(p_addr, exp_rdata & ~p_wdata);
                    default: ;
                endcase
            end
            if (exp_redir_v && p_trap) begin
                m_epc   <= p_pc & ~32'h3;
                m_cause <= (p_irq ? 32'h8000_0000 : 32'h0) | {27'b0, p_cause};
                m_tval  <= p_irq ? 32'h0 : p_tval;
                m_pie   <= m_ie;
                m_ie    <= 1'b0;
            end
            if (exp_redir_v && !p_trap) begin
                m_ie  <= m_pie;
                m_pie <= 1'b1;
            end
            exp_rsp_v <= 1'b0; exp_ill <= 1'b0; exp_rdata <= 32'h0;
            exp_redir_v <= 1'b0; exp_redir_pc <= 32'h0;
            if (!(exp_rsp_v || exp_redir_v)) begin
                if (trap_valid) begin
                    p_trap <= 1'b1; p_irq <= trap_is_irq; p_cause <= trap_cause;
                    p_pc <= trap_pc; p_tval <= trap_tval;
                    exp_redir_v  <= 1'b1;
                    exp_redir_pc <= m_vector(trap_is_irq, trap_cause);
                end else if (mret_valid) begin
                    p_trap <= 1'b0;
                    exp_redir_v  <= 1'b1;
                    exp_redir_pc <= m_epc;
                end else if (csr_req_valid) begin
                    p_op <= csr_op; p_addr <= csr_addr; p_wdata <= csr_wdata;
                    exp_rsp_v <= 1'b1;
                    exp_ill   <= !m_legal(csr_addr, csr_op);
                    exp_rdata <= m_legal(csr_addr, csr_op) ? m_read(csr_addr) : 32'h0;
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic        e_ready, e_pend;
        logic        bad;
        e_ready = !(exp_rsp_v || exp_redir_v) && !trap_valid && !mret_valid;
        e_pend  = m_ie && |(live_mip() & m_mie);
        bad = (csr_req_ready !== e_ready) || (csr_rsp_valid !== exp_rsp_v) ||
              (csr_rsp_illegal !== exp_ill) || (csr_rdata !== exp_rdata) ||
              (redirect_valid !== exp_redir_v) || (redirect_pc !== exp_redir_pc) ||
              (irq_pending !== e_pend);
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL cycle t=%0t got rdy=%b rsp=%b ill=%b rd=%h rv=%b rpc=%h pend=%b need rdy=%b rsp=%b ill=%b rd=%h rv=%b rpc=%h pend=%b",
                $time, csr_req_ready, csr_rsp_valid, csr_rsp_illegal, csr_rdata,
                redirect_valid, redirect_pc, irq_pending,
                e_ready, exp_rsp_v, exp_ill, exp_rdata, exp_redir_v, exp_redir_pc, e_pend);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got %h need %h", name, act, req);
        end
    endtask

    task automatic csr_do(input logic [1:0] op, input logic [11:0] a,
                          input logic [31:0] w, output logic [31:0] rd,
                          output logic ill);
        bit got = 0;
        @(posedge clk); #1;
        csr_req_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = w;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (csr_req_ready) got = 1;
        end
        @(posedge clk); #1;
        csr_req_valid = 1'b0;
        @(negedge clk);
        rd = csr_rdata; ill = csr_rsp_illegal;
        if (!got || !csr_rsp_valid) begin
            tests++; fails++;
            $display("FAIL csr_handshake addr %h got rsp %b need 1", a, csr_rsp_valid);
        end
    endtask

    task automatic trap_do(input logic irq, input logic [4:0] c,
                           input logic [31:0] pc, input logic [31:0] tv,
                           output logic [31:0] rpc);
        bit got = 0;
        rpc = 32'h0;
        @(posedge clk); #1;
        trap_valid = 1'b1; trap_is_irq = irq; trap_cause = c;
        trap_pc = pc; trap_tval = tv;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (redirect_valid) begin got = 1; rpc = redirect_pc; end
        end
        @(posedge clk); #1;
        trap_valid = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL trap_timeout got none need redirect");
        end
    endtask

    task automatic mret_do(output logic [31:0] rpc);
        bit got = 0;
        rpc = 32'h0;
        @(posedge clk); #1;
        mret_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (redirect_valid) begin got = 1; rpc = redirect_pc; end
        end
        @(posedge clk); #1;
        mret_valid = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL mret_timeout got none need redirect");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rpc;
        logic        ill;
        logic [31:0] pcs [2];
        int          n;
        bit          got_rsp;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        csr_do(2'b00, 12'h300, 32'h0, rd, ill); chk("rst_mstatus", rd, 32'h1800);
        csr_do(2'b00, 12'h301, 32'h0, rd, ill); chk("rst_misa", rd, 32'h4000_1100);
        csr_do(2'b00, 12'hF14, 32'h0, rd, ill); chk("mhartid", rd, 32'd3);

        csr_do(2'b10, 12'h304, 32'hFFFF_FFFF, rd, ill); chk("mie_rs_old", rd, 32'h0);
        csr_do(2'b00, 12'h304, 32'h0, rd, ill); chk("mie_rs", rd, 32'h888);
        csr_do(2'b11, 12'h304, 32'h8, rd, ill);
        csr_do(2'b00, 12'h304, 32'h0, rd, ill); chk("mie_rc", rd, 32'h880);
        csr_do(2'b01, 12'h305, 32'h1000_0003, rd, ill);
        csr_do(2'b00, 12'h305, 32'h0, rd, ill); chk("mtvec_warl", rd, 32'h1000_0000);

        csr_do(2'b01, 12'hF11, 32'h1234, rd, ill);
        chk("ill_f11", ill, 1); chk("ill_f11_rd", rd, 0);
        csr_do(2'b00, 12'h7C0, 32'h0, rd, ill); chk("ill_7c0", ill, 1);
        csr_do(2'b10, 12'h301, 32'hFFFF, rd, ill); chk("ill_misa", ill, 1);
        csr_do(2'b00, 12'h301, 32'h0, rd, ill); chk("misa_kept", rd, 32'h4000_1100);

        csr_do(2'b01, 12'h305, 32'h8000_0101, rd, ill);
        csr_do(2'b10, 12'h300, 32'h8, rd, ill);
        trap_do(1'b0, 5'd2, 32'h1236, 32'hDEAD, rpc); chk("exc_redirect", rpc, 32'h8000_0100);
        csr_do(2'b00, 12'h341, 32'h0, rd, ill); chk("exc_mepc", rd, 32'h1234);
        csr_do(2'b00, 12'h342, 32'h0, rd, ill); chk("exc_mcause", rd, 32'h2);
        csr_do(2'b00, 12'h343, 32'h0, rd, ill); chk("exc_mtval", rd, 32'hDEAD);
        csr_do(2'b00, 12'h300, 32'h0, rd, ill); chk("exc_mstatus", rd, 32'h1880);

        csr_do(2'b10, 12'h300, 32'h8, rd, ill);
        @(posedge clk); #1 irq_tim = 1'b1;
        @(negedge clk); chk("irq_pend_on", irq_pending, 1);
        trap_do(1'b1, 5'd7, 32'h2000, 32'h55, rpc); chk("irq_redirect", rpc, 32'h8000_011C);
        @(negedge clk); chk("irq_pend_off", irq_pending, 0);
        csr_do(2'b00, 12'h342, 32'h0, rd, ill); chk("irq_mcause", rd, 32'h8000_0007);
        csr_do(2'b00, 12'h343, 32'h0, rd, ill); chk("irq_mtval", rd, 32'h0);
        mret_do(rpc); chk("mret_redirect", rpc, 32'h2000);
        csr_do(2'b00, 12'h300, 32'h0, rd, ill); chk("mret_mstatus", rd, 32'h1888);
        @(posedge clk); #1 irq_tim = 1'b0;

        csr_do(2'b01, 12'h340, 32'hCAFE_F00D, rd, ill);
        @(posedge clk); #1;
        trap_valid = 1'b1; trap_is_irq = 1'b0; trap_cause = 5'd3;
        trap_pc = 32'h3000; trap_tval = 32'h77;
        mret_valid = 1'b1;
        csr_req_valid = 1'b1; csr_op = 2'b00; csr_addr = 12'h340; csr_wdata = 32'h0;
        @(negedge clk); chk("collide_ready", csr_req_ready, 0);
        n = 0; got_rsp = 0; rd = 32'h0;
        for (int k = 0; k < 20 && !got_rsp; k++) begin
            @(negedge clk);
            if (redirect_valid) begin
                if (n < 2) pcs[n] = redirect_pc;
                n++;
                @(posedge clk); #1;
                if (n == 1) trap_valid = 1'b0;
                else        mret_valid = 1'b0;
            end else if (csr_req_valid && csr_req_ready) begin
                @(posedge clk); #1 csr_req_valid = 1'b0;
            end else if (csr_rsp_valid) begin
                got_rsp = 1; rd = csr_rdata;
            end
        end
        trap_valid = 1'b0; mret_valid = 1'b0; csr_req_valid = 1'b0;
        chk("collide_count", n, 2);
        chk("collide_first", pcs[0], 32'h8000_0100);
        chk("collide_second", pcs[1], 32'h3000);
        chk("collide_rsp", got_rsp, 1);
        chk("collide_rdata", rd, 32'hCAFE_F00D);

        @(posedge clk); #1;
        csr_req_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h305; csr_wdata = 32'h0000_4000;
        @(negedge clk); chk("rst_acc_ready", csr_req_ready, 1);
        @(posedge clk); #1 csr_req_valid = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk); chk("rst_no_rsp", csr_rsp_valid, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        csr_do(2'b00, 12'h305, 32'h0, rd, ill); chk("rst_mtvec", rd, 32'h0);
        csr_do(2'b00, 12'h300, 32'h0, rd, ill); chk("rst_mstatus2", rd, 32'h1800);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
